// File: rtl/vga_pkg.sv
// vga_pkg: shared VGA 640x480@60 timing constants, coordinate width and motion FSM states
// Ports: none (package).
package vga_pkg;
  localparam int DEF_H_ACTIVE = 640;
  localparam int DEF_V_ACTIVE = 480;
  localparam int H_FP = 16;
  localparam int H_SYNC = 96;
  localparam int H_BP = 48;
  localparam int V_FP = 10;
  localparam int V_SYNC = 2;
  localparam int V_BP = 33;
  localparam int COORD_W = 10;
  typedef logic [1:0] state_t;
  localparam state_t S_WAIT = 2'd0;
  localparam state_t S_MOVE_X = 2'd1;
  localparam state_t S_MOVE_Y = 2'd2;
endpackage

// File: rtl/vga_box_renderer_if.sv
// vga_box_renderer_if: raster input from the timing generator and pixel/sync output of the renderer
// Ports: x, y, valid, hs_in, vs_in (timing side -> renderer); hs_out, vs_out, green, frame_done (renderer -> sink).
interface vga_box_renderer_if;
  import vga_pkg::*;
  logic [COORD_W-1:0] x;
  logic [COORD_W-1:0] y;
  logic valid;
  logic hs_in;
  logic vs_in;
  logic hs_out;
  logic vs_out;
  logic green;
  logic frame_done;
  modport master(output x, y, valid, hs_in, vs_in, input hs_out, vs_out, green, frame_done);
  modport slave(input x, y, valid, hs_in, vs_in, output hs_out, vs_out, green, frame_done);
endinterface

// File: rtl/vga_box_axis.sv
// vga_box_axis: single-axis bounce register, moves pos by SPEED toward the current edge on each step
// Ports: clk, rst (sync, active high), step (advance one move), pos (11-bit leading edge).
module vga_box_axis #(
  parameter int ACTIVE = 640,
  parameter int SIZE = 32,
  parameter int SPEED = 2,
  parameter int INIT = 0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        step,
  output logic [10:0] pos
);
  logic dir;
  logic [10:0] n;
  logic hi_hit, lo_hit;
  always_comb begin
    n = pos + 11'(SPEED);
    hi_hit = n + 11'(SIZE) > 11'(ACTIVE);
    lo_hit = pos < 11'(SPEED);
  end
  // dir 0 = toward the high edge (right/down); SPEED=0 can never hit, so it never flips
  always_ff @(posedge clk)
    if (rst) begin
      pos <= 11'(INIT);
      dir <= 1'b0;
    end else if (step) begin
      pos <= !dir ? (hi_hit ? 11'(ACTIVE - SIZE) : n) : (lo_hit ? 11'd0 : pos - 11'(SPEED));
      dir <= !dir ? hi_hit : !lo_hit;
    end
endmodule

// File: rtl/vga_box_renderer.sv
// vga_box_renderer: draws a bouncing solid box (optional checker background) with a 2-cycle pixel pipeline
// Ports: CLK, RST (sync, active high), bus (vga_box_renderer_if.slave: raster in, green/hs_out/vs_out/frame_done out).
// Macro VGA_CHECKER_EN: when defined the background is x[CHK_BIT]^y[CHK_BIT], otherwise black.
module vga_box_renderer import vga_pkg::*; #(
  parameter int H_ACTIVE = DEF_H_ACTIVE,
  parameter int V_ACTIVE = DEF_V_ACTIVE,
  parameter int BOX_W = 32,
  parameter int BOX_H = 32,
  parameter int SPEED = 2,
  parameter int BX0 = 0,
  parameter int BY0 = 0,
  parameter int CHK_BIT = 4
) (
  input logic CLK,
  input logic RST,
  vga_box_renderer_if.slave bus
);
  state_t state;
  logic [10:0] bx, by, xx, yy;
  logic in_box, in_box_d, valid_d, bg, green_q, trig;
  logic [1:0] hs_p, vs_p;
  vga_box_axis #(.ACTIVE(H_ACTIVE), .SIZE(BOX_W), .SPEED(SPEED), .INIT(BX0)) u_ax (
    .clk(CLK), .rst(RST), .step(state == S_MOVE_X), .pos(bx)
  );
  vga_box_axis #(.ACTIVE(V_ACTIVE), .SIZE(BOX_H), .SPEED(SPEED), .INIT(BY0)) u_ay (
    .clk(CLK), .rst(RST), .step(state == S_MOVE_Y), .pos(by)
  );
  always_comb begin
    xx = {1'b0, bus.x};
    yy = {1'b0, bus.y};
    in_box = xx >= bx && xx < bx + 11'(BOX_W) && yy >= by && yy < by + 11'(BOX_H);
    // first blanking line start: fires once per frame, well inside vertical blanking
    trig = bus.x == '0 && bus.y == COORD_W'(V_ACTIVE);
  end
`ifdef VGA_CHECKER_EN
  logic chk_d;
  always_ff @(posedge CLK)
    if (RST) chk_d <= 1'b0;
    else chk_d <= bus.x[CHK_BIT] ^ bus.y[CHK_BIT];
  assign bg = chk_d;
`else
  assign bg = 1'b0;
`endif
  always_ff @(posedge CLK)
    if (RST) begin
      in_box_d <= 1'b0;
      valid_d <= 1'b0;
      green_q <= 1'b0;
      hs_p <= 2'b11;
      vs_p <= 2'b11;
      state <= S_WAIT;
    end else begin
      in_box_d <= in_box;
      valid_d <= bus.valid;
      green_q <= valid_d & (in_box_d | bg);
      hs_p <= {hs_p[0], bus.hs_in};
      vs_p <= {vs_p[0], bus.vs_in};
      state <= state == S_WAIT ? (trig ? S_MOVE_X : S_WAIT) : state == S_MOVE_X ? S_MOVE_Y : S_WAIT;
    end
  assign bus.green = green_q;
  assign bus.hs_out = hs_p[1];
  assign bus.vs_out = vs_p[1];
  assign bus.frame_done = state == S_MOVE_Y;
endmodule

// File: tb/tb_vga_box_renderer.sv
// tb_vga_box_renderer: randomized raster stimulus checked against a frame-level box/bounce reference model
module tb_vga_box_renderer;
  localparam int HA = 640, VA = 480, BW = 31, BH = 32, SP = 2, BX0 = 605, BY0 = 0, CB = 4;
  logic CLK = 1'b0;
  logic RST = 1'b1;
  int checks = 0, errors = 0;
  int mbx, mby, mdx, mdy, pend;
  logic [2:0] d1, d2;
  vga_box_renderer_if bus();
  vga_box_renderer #(.H_ACTIVE(HA), .V_ACTIVE(VA), .BOX_W(BW), .BOX_H(BH), .SPEED(SP),
    .BX0(BX0), .BY0(BY0), .CHK_BIT(CB)) dut (.CLK(CLK), .RST(RST), .bus(bus));
  always #20 CLK = ~CLK;
  task automatic check(input string tag, input int got, input int exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (bx=%0d by=%0d t=%0t)", tag, got, exp, mbx, mby, $time);
    end
  endtask
  // one axis move from the bounce rules; returns new position, flips d when an edge is hit
  function automatic int move(input int p, inout int d, input int size, input int act);
    int n;
    if (d == 0) begin
      n = p + SP;
      if (n + size > act) begin d = 1; return act - size; end
      return n;
    end
    if (p < SP) begin d = 0; return 0; end
    return p - SP;
  endfunction
  function automatic logic pix(input int x, input int y, input logic v);
    logic bgm;
    bgm = 1'b0;
`ifdef VGA_CHECKER_EN
    bgm = logic'(((x >> CB) ^ (y >> CB)) & 1);
`endif
    return v && ((x >= mbx && x < mbx + BW && y >= mby && y < mby + BH) || bgm);
  endfunction
  task automatic model_reset();
    mbx = BX0; mby = BY0; mdx = 0; mdy = 0; pend = 0;
    d1 = 3'b011; d2 = 3'b011;
  endtask
  task automatic tick(input int xi, input int yi, input logic v, input logic h, input logic vv, input logic r);
    logic eg;
    logic [9:0] xs, ys;
    xs = xi[9:0]; ys = yi[9:0];
    bus.x = xs; bus.y = ys; bus.valid = v; bus.hs_in = h; bus.vs_in = vv; RST = r;
    eg = pix(xi, yi, v);
    @(posedge CLK);
    if (r) model_reset();
    else begin
      d2 = d1;
      d1 = {eg, h, vv};
      if (pend == 2) begin mbx = move(mbx, mdx, BW, HA); pend = 1; end
      else if (pend == 1) begin mby = move(mby, mdy, BH, VA); pend = 0; end
      else if (xi == 0 && yi == VA) pend = 2;
    end
    @(negedge CLK);
    check("green", int'(bus.green), int'(d2[2]));
    check("hs_out", int'(bus.hs_out), int'(d2[1]));
    check("vs_out", int'(bus.vs_out), int'(d2[0]));
    check("frame_done", int'(bus.frame_done), int'(pend == 1));
  endtask
  task automatic frame_end();
    tick(0, VA, 0, 1, 1, 0);
    for (int i = 0; i < 3; i++) tick(1, VA + 1, 0, 1, 1, 0);
  endtask
  initial begin
    model_reset();
    bus.x = '0; bus.y = '0; bus.valid = 1'b0; bus.hs_in = 1'b1; bus.vs_in = 1'b1;
    for (int i = 0; i < 3; i++) tick(5, 5, 1, 0, 0, 1);
    tick(5, 5, 1, 0, 1, 0);
    tick(40, 5, 1, 1, 0, 0);
    tick(5, 5, 0, 1, 1, 0);
    tick(605, 0, 1, 1, 1, 0);
    tick(635, 31, 1, 1, 1, 0);
    tick(636, 0, 1, 1, 1, 0);
    tick(604, 10, 1, 1, 1, 0);
    tick(620, 32, 1, 1, 1, 0);
    tick(620, 20, 0, 1, 1, 0);
    for (int f = 0; f < 700; f++) begin
      if (f == 5) begin
        tick(0, VA, 0, 1, 1, 0);
        tick(1, VA + 1, 0, 1, 1, 1);
        tick(1, VA + 1, 0, 1, 1, 0);
        tick(BX0, BY0, 1, 1, 1, 0);
      end
      for (int i = 0; i < 12; i++) begin
        int x, y;
        if ($urandom_range(0, 1) == 1) begin
          x = mbx - 3 + int'($urandom_range(0, BW + 5));
          y = mby - 3 + int'($urandom_range(0, BH + 5));
          x = x < 0 ? 0 : x > HA - 1 ? HA - 1 : x;
          y = y < 0 ? 0 : y > VA - 1 ? VA - 1 : y;
        end else begin
          x = int'($urandom_range(0, HA - 1));
          y = int'($urandom_range(0, VA - 1));
        end
        tick(x, y, logic'($urandom_range(0, 4) != 0), logic'($urandom_range(0, 9) != 0),
             logic'($urandom_range(0, 9) != 0), 0);
      end
      frame_end();
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
